// File: rtl/sprite_plotter_pkg.sv
// sprite_plotter_pkg: screen/sprite geometry, erase colour and sequencer states
package sprite_plotter_pkg;
   localparam int SCR_W = 160;
   localparam int SCR_H = 120;
   localparam int SPR_W = 16;
   localparam int SPR_H = 32;
   localparam int Y_OFF = 9;
   localparam logic [2:0] BG_COLOR = 3'b111;
   localparam int CX_W = $clog2(SPR_W);
   localparam int CY_W = $clog2(SPR_H);
   typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_e;
endpackage

// File: rtl/sprite_plotter_box_scanner.sv
// box_scanner: walks the sprite box row by row and clips each pixel to the screen
module box_scanner
   import sprite_plotter_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [7:0]        base_x,
   input  logic [6:0]        base_y,
   output logic [8:0]        px,
   output logic signed [8:0] py,
   output logic              on_screen,
   output logic              last
);
   logic [CX_W-1:0] cx_q, cx_d;
   logic [CY_W-1:0] cy_q, cy_d;
   // x advances every cycle, y steps when x wraps; start rewinds to the box corner
   always_comb begin
      cx_d = start ? '0 : cx_q + 1'b1;
      cy_d = start ? '0 : (&cx_q ? cy_q + 1'b1 : cy_q);
   end
   // scan position registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cx_q <= '0;
         cy_q <= '0;
      end else begin
         cx_q <= cx_d;
         cy_q <= cy_d;
      end
   end
   // py can go negative for boxes near the top edge, so bit 8 acts as the sign
   always_comb begin
      px        = {1'b0, base_x} + 9'(cx_q);
      py        = 9'({2'b00, base_y} + 9'(cy_q) - 9'(Y_OFF));
      on_screen = (px < 9'(SCR_W)) && !py[8] && (py[7:0] < 8'(SCR_H));
      last      = (&cx_q) && (&cy_q);
   end
endmodule

// File: rtl/sprite_plotter.sv
// sprite_plotter: erases the old sprite box and redraws it at the new position, one plot per cycle
module sprite_plotter
   import sprite_plotter_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       req,
   input  logic [7:0] new_x,
   input  logic [6:0] new_y,
   output logic       busy,
   output logic       done,
   output logic [7:0] pos_x,
   output logic [6:0] pos_y,
   output logic [7:0] qry_x,
   output logic [6:0] qry_y,
   input  logic [2:0] pix_color,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot
);
   state_e            state_q, state_d;
   logic              have_old_q, have_old_d;
   logic [7:0]        pos_x_q, pos_x_d, old_x_q, old_x_d, vga_x_q, vga_x_d;
   logic [6:0]        pos_y_q, pos_y_d, old_y_q, old_y_d, vga_y_q, vga_y_d;
   logic [2:0]        vga_colour_q, vga_colour_d;
   logic              vga_plot_q, vga_plot_d;
   logic              start, on_screen, last;
   logic [8:0]        px;
   logic signed [8:0] py;
   logic [7:0]        base_x;
   logic [6:0]        base_y;

   box_scanner u_scan (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .base_x    (base_x),
      .base_y    (base_y),
      .px        (px),
      .py        (py),
      .on_screen (on_screen),
      .last      (last)
   );

   // next-state logic: accept a move in IDLE, sweep erase then draw, pulse done
   always_comb begin
      state_d      = state_q;
      have_old_d   = have_old_q;
      pos_x_d      = pos_x_q;
      pos_y_d      = pos_y_q;
      old_x_d      = old_x_q;
      old_y_d      = old_y_q;
      start        = 1'b0;
      base_x       = (state_q == S_ERASE) ? old_x_q : pos_x_q;
      base_y       = (state_q == S_ERASE) ? old_y_q : pos_y_q;
      unique case (state_q)
         S_IDLE: if (req) begin
            old_x_d    = pos_x_q;
            old_y_d    = pos_y_q;
            pos_x_d    = new_x;
            pos_y_d    = new_y;
            start      = 1'b1;
            state_d    = have_old_q ? S_ERASE : S_DRAW;
            have_old_d = 1'b1;
         end
         S_ERASE: if (last) begin
            start   = 1'b1;
            state_d = S_DRAW;
         end
         S_DRAW:  if (last) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
      vga_plot_d   = on_screen && (state_q == S_ERASE || state_q == S_DRAW);
      vga_x_d      = px[7:0];
      vga_y_d      = py[6:0];
      vga_colour_d = (state_q == S_ERASE) ? BG_COLOR : pix_color;
   end

   // state, positions and the registered VGA write port
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         have_old_q   <= 1'b0;
         pos_x_q      <= '0;
         pos_y_q      <= '0;
         old_x_q      <= '0;
         old_y_q      <= '0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         have_old_q   <= have_old_d;
         pos_x_q      <= pos_x_d;
         pos_y_q      <= pos_y_d;
         old_x_q      <= old_x_d;
         old_y_q      <= old_y_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
         vga_plot_q   <= vga_plot_d;
      end
   end

   assign busy       = state_q != S_IDLE;
   assign done       = state_q == S_DONE;
   assign pos_x      = pos_x_q;
   assign pos_y      = pos_y_q;
   assign qry_x      = px[7:0];
   assign qry_y      = py[6:0];
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign vga_plot   = vga_plot_q;
endmodule

// File: tb/tb_sprite_plotter.sv
// tb_sprite_plotter: scoreboard bench for the sprite erase/redraw sequencer
module tb_sprite_plotter;
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       req = 1'b0;
   logic [7:0] new_x = '0;
   logic [6:0] new_y = '0;
   logic       busy, done, vga_plot;
   logic [7:0] pos_x, qry_x, vga_x;
   logic [6:0] pos_y, qry_y, vga_y;
   logic [2:0] pix_color, vga_colour;
   logic       stub_const = 1'b1;

   logic [17:0] sb[$];
   int total = 0, bad = 0, plots = 0, dones = 0;
   int have_old = 0, mx = 0, my = 0;

   always #5 clk = ~clk;

   // renderer stub: fixed colour, or a coordinate hash so misplaced pixels show up
   assign pix_color = stub_const ? 3'b011 : (qry_x[2:0] ^ {qry_y[1:0], 1'b0});

   sprite_plotter dut (
      .clk        (clk),
      .resetn     (resetn),
      .req        (req),
      .new_x      (new_x),
      .new_y      (new_y),
      .busy       (busy),
      .done       (done),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .qry_x      (qry_x),
      .qry_y      (qry_y),
      .pix_color  (pix_color),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_box(input int bx, input int by, input bit erase);
      for (int cy = 0; cy < 32; cy++)
         for (int cx = 0; cx < 16; cx++) begin
            int x, y;
            logic [7:0] xv;
            logic [6:0] yv;
            logic [2:0] c;
            x = bx + cx;
            y = by + cy - 9;
            if (x < 160 && y >= 0 && y < 120) begin
               xv = x[7:0];
               yv = y[6:0];
               c = erase ? 3'b111 : (stub_const ? 3'b011 : (xv[2:0] ^ {yv[1:0], 1'b0}));
               sb.push_back({xv, yv, c});
            end
         end
   endtask

   // compare every plot against the scoreboard head
   always @(negedge clk) begin
      if (vga_plot === 1'b1) begin
         plots++;
         if (sb.size() == 0) chk("extra_plot", sb.size(), 1);
         else chk("plot", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, sb.pop_front()});
      end
      if (done === 1'b1) dones++;
   end

   task automatic do_reset();
      resetn = 1'b0;
      req = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      sb.delete();
      have_old = 0;
      mx = 0;
      my = 0;
   endtask

   task automatic run(input logic [7:0] x, input logic [6:0] y, input int ign, input int abort, input int exp_plots);
      int n, p0, d0, exp_done;
      @(negedge clk);
      req = 1'b1;
      new_x = x;
      new_y = y;
      if (have_old != 0) push_box(mx, my, 1'b1);
      push_box(int'(x), int'(y), 1'b0);
      exp_done = (have_old != 0) ? 1025 : 513;
      have_old = 1;
      mx = int'(x);
      my = int'(y);
      p0 = plots;
      d0 = dones;
      n = 0;
      @(posedge clk);
      #1 req = 1'b0;
      while (n < 2000) begin
         @(negedge clk);
         n++;
         if (n == ign) begin
            req = 1'b1;
            new_x = 8'd90;
            new_y = 7'd90;
         end else req = 1'b0;
         if (n == abort) begin
            resetn = 1'b0;
            #1;
            chk("abort_plot", vga_plot, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_pos", {pos_x, pos_y}, 0);
            chk("abort_vga", {vga_x, vga_y, vga_colour}, 0);
            sb.delete();
            have_old = 0;
            mx = 0;
            my = 0;
            @(negedge clk);
            chk("abort_quiet", vga_plot, 0);
            resetn = 1'b1;
            return;
         end
         if (done === 1'b1) break;
      end
      chk("done_cyc", n, exp_done);
      @(negedge clk);
      chk("busy_after", busy, 0);
      chk("done_cnt", dones - d0, 1);
      chk("plot_cnt", plots - p0, exp_plots);
      chk("sb_empty", sb.size(), 0);
      chk("pos", {pos_x, pos_y}, {x, y});
   endtask

   initial begin
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_plot", vga_plot, 0);
      chk("rst_pos", {pos_x, pos_y}, 0);
      chk("rst_vga", {vga_x, vga_y, vga_colour}, 0);
      do_reset();
      run(8'd40, 7'd60, 0, 0, 512);
      stub_const = 1'b0;
      run(8'd41, 7'd60, 0, 0, 1024);
      do_reset();
      run(8'd150, 7'd5, 0, 0, 280);
      run(8'd70, 7'd40, 100, 0, 792);
      do_reset();
      run(8'd20, 7'd30, 0, 300, 0);
      run(8'd40, 7'd60, 0, 0, 512);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
